sum_uart_tx: RTL and testbench



---
 rtl/sum_uart_pkg.sv | 24 ++
 rtl/sum_uart_tx_if.sv | 21 ++
 rtl/sum_fifo.sv | 69 ++++++
 rtl/sum_uart_tx.sv | 134 +++++++++++++
 tb/tb_sum_uart_tx.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sum_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sum_uart_pkg
// Description : Shared types and constants for the sum UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package sum_uart_pkg;

    localparam int DEF_DATA_W       = 5;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int DEF_CLKS_PER_BIT = 4;

    localparam int FRAME_BITS = 10;
    localparam int PAYLOAD_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sum_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : sum_uart_tx_if
// Description : Valid/ready handshake carrying sums into the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface sum_uart_tx_if
    import sum_uart_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface
`default_nettype wire

// File: rtl/sum_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sum_fifo
// Description : Circular FIFO, synchronous write, head visible on dout_o.
// Revision    : 1.0 - initial release
// ============================================================================
module sum_fifo
    import sum_uart_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_FIFO_DEPTH
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push_i,
    input  wire logic [DATA_W-1:0]        din_i,
    input  wire logic                     pop_i,
    output logic      [DATA_W-1:0]        dout_o,
    output logic      [$clog2(DEPTH):0]   count_o,
    output logic                          full_o,
    output logic                          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              w_push;
    logic              w_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sum_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : sum_uart_tx
// Description : Buffers adder sums and sends each one as an 8N1 serial frame.
// Revision    : 1.0 - initial release
// ============================================================================
module sum_uart_tx
    import sum_uart_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    sum_uart_tx_if.slave                     in_if,
    output logic                             tx,
    output logic                             busy,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(PAYLOAD_W);
    localparam logic [BW-1:0] c_BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_BIT_LAST  = CW'(PAYLOAD_W - 1);

    state_t                 state_q;
    logic [BW-1:0]          baud_q;
    logic [CW-1:0]          bit_q;
    logic [PAYLOAD_W-1:0]   shift_q;
    logic                   tx_q;

    logic [DATA_W-1:0]      w_dout;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_baud_last;

    // Ready looks only at the stored count, so a same-cycle pop never frees a slot.
    assign in_if.in_ready = !w_full && !rst;
    assign w_push         = in_if.in_valid && in_if.in_ready;
    assign w_baud_last    = (baud_q == c_BAUD_LAST);
    assign w_pop          = !w_empty &&
                            ((state_q == IDLE) || ((state_q == STOP) && w_baud_last));

    assign tx   = tx_q;
    assign busy = (state_q != IDLE) || !w_empty;

    sum_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .din_i   (in_if.in_data),
        .pop_i   (w_pop),
        .dout_o  (w_dout),
        .count_o (fifo_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    bit_q  <= '0;
                    tx_q   <= 1'b1;
                    if (!w_empty) begin
                        shift_q <= PAYLOAD_W'(w_dout);
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (w_baud_last) begin
                        baud_q  <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                DATA: begin
                    if (w_baud_last) begin
                        baud_q <= '0;
                        if (bit_q == c_BIT_LAST) begin
                            bit_q   <= '0;
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q   <= bit_q + CW'(1);
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                STOP: begin
                    if (w_baud_last) begin
                        baud_q <= '0;
                        // Chain straight into the next start bit when data is waiting.
                        if (!w_empty) begin
                            shift_q <= PAYLOAD_W'(w_dout);
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sum_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_uart_tx
// Description : Directed self-checking bench for sum_uart_tx (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    sum_uart_tx_if #(.DATA_W(5)) bus ();

    sum_uart_tx #(
        .DATA_W       (5),
        .FIFO_DEPTH   (4),
        .CLKS_PER_BIT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_if      (bus),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Line decoder: 40 samples per frame, bit 8 of each entry flags a malformed frame.
    logic [8:0]  rx_q [$];
    int          rx_cyc_q [$];
    bit          m_act = 1'b0;
    int          m_pos;
    int          m_start;
    logic [39:0] m_sh;
    logic        m_err;
    logic [7:0]  m_b;

    always @(posedge clk) begin
        #1;
        if (rst !== 1'b0) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (tx === 1'b0) begin
                m_act   = 1'b1;
                m_pos   = 1;
                m_sh    = '0;
                m_start = cyc;
            end
        end else begin
            m_sh[m_pos] = tx;
            if (m_pos == 39) begin
                m_err = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    if (m_sh[4*i +: 4] !== {4{m_sh[4*i]}}) m_err = 1'b1;
                end
                if (m_sh[36] !== 1'b1) m_err = 1'b1;
                for (int i = 0; i < 8; i++) m_b[i] = m_sh[4*(i+1)];
                rx_q.push_back({m_err, m_b});
                rx_cyc_q.push_back(m_start);
                m_act = 1'b0;
            end else begin
                m_pos++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t = 0;
        while (rx_q.size() < n && t < budget) begin
            step(1);
            t++;
        end
        chk("frame_wait", 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic stream(input logic [4:0] vals [9], input int n, input int budget,
                          output bit saw_full);
        int idx = 0;
        int t   = 0;
        saw_full = 1'b0;
        while (idx < n && t < budget) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vals[idx];
            chk("ready_vs_count", 32'(bus.in_ready), 32'(fifo_count != 3'd4));
            if (fifo_count == 3'd4) saw_full = 1'b1;
            if (bus.in_ready) idx++;
            step(1);
            t++;
        end
        bus.in_valid = 1'b0;
        chk("stream_done", idx, n);
    endtask

    task automatic check_rx(input logic [4:0] vals [9], input int n);
        chk("frame_count", rx_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < rx_q.size()) chk("frame_payload", 32'(rx_q[i]), {27'd0, vals[i]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] v [9];
        bit         full_seen;
        int         push_cyc;
        int         t;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        step(3);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Single push of 19 into an empty FIFO.
        step(1);
        bus.in_valid = 1'b1;
        bus.in_data  = 5'd19;
        step(1);
        bus.in_valid = 1'b0;
        push_cyc = cyc;
        chk("single_count", 32'(fifo_count), 32'd1);
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_tx_idle", 32'(tx), 32'd1);
        step(1);
        chk("single_start_low", 32'(tx), 32'd0);
        chk("single_popped", 32'(fifo_count), 32'd0);
        step(39);
        chk("single_busy_end", 32'(busy), 32'd1);
        step(1);
        chk("single_busy_fall", 32'(busy), 32'd0);
        chk("single_tx_high", 32'(tx), 32'd1);
        wait_frames(1, 5);
        v = '{5'd19, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        check_rx(v, 1);
        if (rx_cyc_q.size() > 0) chk("single_latency", rx_cyc_q[0] - push_cyc, 32'd1);

        // Two consecutive pushes: back-to-back frames.
        rx_q.delete();
        rx_cyc_q.delete();
        step(2);
        bus.in_valid = 1'b1;
        bus.in_data  = 5'd30;
        step(1);
        chk("b2b_count1", 32'(fifo_count), 32'd1);
        bus.in_data  = 5'd0;
        step(1);
        bus.in_valid = 1'b0;
        chk("b2b_count2", 32'(fifo_count), 32'd1);
        wait_frames(2, 120);
        v = '{5'd30, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        check_rx(v, 2);
        if (rx_cyc_q.size() > 1) chk("b2b_gap", rx_cyc_q[1] - rx_cyc_q[0], 32'd40);

        // in_valid held high with 1..6.
        rx_q.delete();
        rx_cyc_q.delete();
        step(2);
        v = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd0, 5'd0, 5'd0};
        stream(v, 6, 400, full_seen);
        chk("hold_saw_full", 32'(full_seen), 32'd1);
        wait_frames(6, 400);
        check_rx(v, 6);

        // Full FIFO, pop and in_valid in the same cycle.
        rx_q.delete();
        rx_cyc_q.delete();
        step(2);
        v = '{5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd0, 5'd0, 5'd0};
        stream(v, 5, 100, full_seen);
        chk("full_count4", 32'(fifo_count), 32'd4);
        bus.in_valid = 1'b1;
        bus.in_data  = 5'd22;
        t = 0;
        while (fifo_count == 3'd4 && t < 60) begin
            chk("full_ready_low", 32'(bus.in_ready), 32'd0);
            step(1);
            t++;
        end
        chk("full_pop_count3", 32'(fifo_count), 32'd3);
        chk("full_ready_rise", 32'(bus.in_ready), 32'd1);
        step(1);
        bus.in_valid = 1'b0;
        chk("full_refill", 32'(fifo_count), 32'd4);
        wait_frames(6, 400);
        check_rx(v, 6);

        // Reset in the data bits of the second frame with two entries queued.
        rx_q.delete();
        rx_cyc_q.delete();
        step(2);
        v = '{5'd7, 5'd8, 5'd9, 5'd10, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        stream(v, 4, 50, full_seen);
        wait_frames(1, 100);
        step(6);
        chk("mid_count", 32'(fifo_count), 32'd2);
        chk("mid_tx_bit0", 32'(tx), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        step(2);
        rst = 1'b0;
        step(60);
        chk("post_rst_frames", rx_q.size(), 32'd1);
        chk("post_rst_tx", 32'(tx), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_count", 32'(fifo_count), 32'd0);
        chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

        // Nine values through the 4-entry FIFO: pointers wrap twice.
        rx_q.delete();
        rx_cyc_q.delete();
        v = '{5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29};
        stream(v, 9, 600, full_seen);
        wait_frames(9, 500);
        check_rx(v, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
